seq_detect_1101: RTL and testbench
==================================

SEQ_DETECT_1101 -- requirements
Module: seq_detect_1101

Interface
REQ-001 Parameter: CNT_W, default 8, width of the detection counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: en  input  1  qualifies din; a bit is consumed only on rising edges where en=1.
REQ-005 Port: din  input  1  serial bit stream from the upstream FSM output y.
REQ-006 Port: clr  input  1  synchronous clear of det_cnt.
REQ-007 Port: det  output  1  registered one-cycle pulse marking a completed "1101" match.
REQ-008 Port: det_cnt  output  CNT_W  saturating count of matches since reset or clr.
REQ-009 Port: state_o  output  2  current FSM state encoding, for debug and observation.

Function
REQ-010 Detect the bit sequence 1,1,0,1 in consumed order (oldest first); overlapping matches count.
REQ-011 FSM states and encoding: S0=2'd0 (no progress), S1=2'd1 ("1"), S11=2'd2 ("11"), S110=2'd3 ("110").
REQ-012 Transitions on consumed din=0: S0->S0, S1->S0, S11->S110, S110->S0.
REQ-013 Transitions on consumed din=1: S0->S1, S1->S11, S11->S11, S110->S1 (match; overlap keeps the trailing "1").
REQ-014 Hold the state unchanged on any edge where en=0.
REQ-015 On the edge that consumes din=1 in S110, register det=1 for exactly one cycle.
REQ-016 Register det=0 on every other edge, including edges where en=0.
REQ-017 Latency: det is high in the cycle immediately after the edge that consumes the final "1".
REQ-018 On the same edge that sets det, increment det_cnt by 1.
REQ-019 det_cnt saturates at 2^CNT_W-1 and never wraps; det still pulses while saturated.
REQ-020 clr=1 sets det_cnt to 0 on that edge and takes priority over a simultaneous increment.
REQ-021 clr does not affect the FSM state or det; a match on the clr edge still pulses det.
REQ-022 state_o equals the registered state encoding with no combinational path from din.
REQ-023 Treat an X or Z on din as don't-care only while en=0.

Reset
REQ-024 While rst=1, immediately and asynchronously force state=S0, det=0, det_cnt=0.
REQ-025 rst asserted mid-pattern (for example in S110) discards all partial progress.
REQ-026 After rst deasserts, the first consumed bit is evaluated from S0.
REQ-027 rst dominates clr and en.

Verification
REQ-028 rst pulse, then en=1 with din=1,1,0,1 on four edges -> det=1 only in the cycle after edge 4; det_cnt=1; state_o=1.
REQ-029 en=1 with din=1,1,0,1,1,0,1 -> det pulses after edges 4 and 7; det_cnt=2.
REQ-030 en=1 with din driven from the upstream toggler (0,1,0,1,...) for 20 edges -> det never asserts; det_cnt=0; state_o alternates 0 and 1.
REQ-031 din=1,1,0 with en=1, then en=0 for 3 edges with din=1, then en=1 with din=1 -> state_o holds 3 while en=0; det pulses after the final edge; det_cnt=1.
REQ-032 CNT_W=2 with 5 matches -> det_cnt reads 1,2,3,3,3; det pulses all 5 times; then clr on the edge of a 6th match -> det_cnt=0 and det=1.
REQ-033 rst asserted asynchronously between edges while in S110 -> state_o=0, det=0, det_cnt=0 before the next clk edge; following din=1 gives no det.

Source files
------------

// File: rtl/seq_detect_1101.sv
// Serial "1101" pattern detector with overlap, one-cycle registered match pulse
// and a saturating, synchronously clearable match counter.
module seq_detect_1101 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             det,
    output logic [CNT_W-1:0] det_cnt,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S11  = 2'd2,
        S110 = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             det_q;
    logic             det_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // Next-state, match pulse and counter update.
    always_comb begin
        state_d = state_q;
        det_d   = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            case (state_q)
                S0:      state_d = din ? S1  : S0;
                S1:      state_d = din ? S11 : S0;
                S11:     state_d = din ? S11 : S110;
                S110: begin
                    // Match keeps the trailing "1" so overlapping patterns count.
                    state_d = din ? S1 : S0;
                    det_d   = din;
                end
                default: state_d = S0;
            endcase
        end else begin
            state_d = state_q;
        end
        if (clr) begin
            cnt_d = '0;
        end else if (det_d) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, pulse and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            det_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            cnt_q   <= cnt_d;
        end
    end

    assign det     = det_q;
    assign det_cnt = cnt_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_seq_detect_1101.sv
// Directed bench for seq_detect_1101: a vector table plus hand-written
// saturation, clear and asynchronous-reset sequences on two counter widths.
module tb_seq_detect_1101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       din = 1'b0;
    logic       clr = 1'b0;
    logic       det8;
    logic [7:0] cnt8;
    logic [1:0] st8;
    logic       det2;
    logic [1:0] cnt2;
    logic [1:0] st2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       en;
        logic       din;
        logic       clr;
        logic [1:0] st;
        logic       det;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    seq_detect_1101 #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .det(det8), .det_cnt(cnt8), .state_o(st8)
    );

    seq_detect_1101 #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .det(det2), .det_cnt(cnt2), .state_o(st2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic d, input logic c,
                       input logic [1:0] s, input logic dt, input logic [7:0] n);
        vec_t v;
        v.en = e; v.din = d; v.clr = c; v.st = s; v.det = dt; v.cnt = n;
        vecs.push_back(v);
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input logic e, input logic d, input logic c);
        en = e; din = d; clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Basic match, overlap, toggler input, en stalls (with X on din), clear.
        add(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 8'd1);
        add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'd1);
        add(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 8'd1);
        add(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 8'd2);
        for (int i = 0; i < 9; i++) begin
            add(1'b1, (i % 2 == 1) ? 1'b1 : 1'b0, 1'b0,
                (i % 2 == 1) ? 2'd1 : 2'd0, 1'b0, 8'd2);
        end
        add(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'd2);
        add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'd2);
        add(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 8'd2);
        add(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 8'd2);
        add(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 8'd2);
        add(1'b0, 1'bx, 1'b0, 2'd3, 1'b0, 8'd2);
        add(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 8'd3);
        add(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'd0);
        add(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 8'd0);
        add(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'd0);

        do_reset();
        chk("reset_state", {6'd0, st8}, 8'd0);
        chk("reset_det", {7'd0, det8}, 8'd0);
        chk("reset_cnt", cnt8, 8'd0);

        foreach (vecs[i]) begin
            cyc(vecs[i].en, vecs[i].din, vecs[i].clr);
            chk($sformatf("v%0d_state", i), {6'd0, st8}, {6'd0, vecs[i].st});
            chk($sformatf("v%0d_det", i), {7'd0, det8}, {7'd0, vecs[i].det});
            chk($sformatf("v%0d_cnt8", i), cnt8, vecs[i].cnt);
            chk($sformatf("v%0d_det2", i), {7'd0, det2}, {7'd0, vecs[i].det});
            chk($sformatf("v%0d_cnt2", i), {6'd0, cnt2}, vecs[i].cnt);
        end

        // Toggler stream from reset: never matches, state alternates 0/1.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, (i % 2 == 1) ? 1'b1 : 1'b0, 1'b0);
            chk($sformatf("tog%0d_state", i), {6'd0, st8}, (i % 2 == 1) ? 8'd1 : 8'd0);
            chk($sformatf("tog%0d_det", i), {7'd0, det8}, 8'd0);
        end
        chk("tog_cnt", cnt8, 8'd0);

        // Five overlapping matches: narrow counter saturates, wide one keeps counting.
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        for (int m = 1; m <= 5; m++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("sat%0d_det2", m), {7'd0, det2}, 8'd1);
            chk($sformatf("sat%0d_cnt2", m), {6'd0, cnt2}, (m > 3) ? 8'd3 : 8'(m));
            chk($sformatf("sat%0d_cnt8", m), cnt8, 8'(m));
            cyc(1'b1, 1'b1, 1'b0);
            chk($sformatf("sat%0d_detoff", m), {7'd0, det2}, 8'd0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clrmatch_det2", {7'd0, det2}, 8'd1);
        chk("clrmatch_cnt2", {6'd0, cnt2}, 8'd0);
        chk("clrmatch_cnt8", cnt8, 8'd0);

        // Asynchronous reset while det is high.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("pre_arst_det", {7'd0, det8}, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_det_async", {7'd0, det8}, 8'd0);
        chk("arst_cnt_async", cnt8, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset in S110 with a nonzero count.
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pre_s110_state", {6'd0, st8}, 8'd3);
        chk("pre_s110_cnt", cnt8, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("s110_arst_state", {6'd0, st8}, 8'd0);
        chk("s110_arst_det", {7'd0, det8}, 8'd0);
        chk("s110_arst_cnt", cnt8, 8'd0);
        // rst held across an edge dominates en/din/clr.
        en = 1'b1; din = 1'b1; clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_dom_state", {6'd0, st8}, 8'd0);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);
        chk("post_rst_state", {6'd0, st8}, 8'd1);
        chk("post_rst_det", {7'd0, det8}, 8'd0);
        chk("post_rst_cnt", cnt8, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
